// File: rtl/irom_banked_pipe_pkg.sv
// Shared types and the ROM image for the banked instruction ROM.
//   irom_meta_t  : per-request metadata carried alongside the bank reads
//                  (valid, word parity of the request, halfword offset, fault)
//   irom_image() : build-time ROM contents; each bank evaluates it for its own
//                  word parity, so the image is split even/odd at elaboration.
package irom_banked_pipe_pkg;

    localparam int IROM_XLEN   = 64;
    localparam int IROM_OFF    = $clog2(IROM_XLEN / 8);
    localparam int IROM_HALVES = IROM_XLEN / 16;
    // Halfword offset field is sized for the widest supported XLEN (64).
    localparam int IROM_H_W    = 2;

    typedef struct packed {
        logic                valid;
        logic                odd;    // request word index was odd: current word sits in the odd bank
        logic [IROM_H_W-1:0] h;
        logic                fault;
    } irom_meta_t;

    // Words 0, 1 and the last word carry fixed marker patterns; every other
    // word holds four halfwords tagged with their position and word index.
    function automatic logic [63:0] irom_image(input logic [11:0] w, input logic [11:0] last);
        logic [15:0] t;
        t = {4'h0, w};
        if (w == 12'd0)
            return 64'hAAAA_3333_2222_1111;
        else if (w == 12'd1)
            return 64'h7777_6666_5555_BBBB;
        else if (w == last)
            return 64'hFFFF_EEEE_DDDD_CCCC;
        else
            return {16'h4000 | t, 16'h3000 | t, 16'h2000 | t, 16'h1000 | t};
    endfunction

endpackage

// File: rtl/irom_meta_pipe.sv
// Metadata / data delay line for the banked ROM.
//   clk, reset : clock, synchronous active-high reset (clears all valids)
//   flush      : clears all valids at the next edge
//   hold       : freeze; every stage keeps its contents
//   in_meta    : metadata of the request being accepted this cycle
//   in_data    : bank outputs, already aligned with metadata stage 0
//   out_meta   : metadata after LATENCY stages
//   out_data   : bank data after LATENCY-1 further stages (aligned with out_meta)
module irom_meta_pipe
    import irom_banked_pipe_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DW      = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            hold,
    input  irom_meta_t      in_meta,
    input  logic [DW-1:0]   in_data,
    output irom_meta_t      out_meta,
    output logic [DW-1:0]   out_data
);

    irom_meta_t meta_q [LATENCY];
    irom_meta_t meta_d [LATENCY];

    always_comb begin
        meta_d = meta_q;
        if (flush) begin
            for (int i = 0; i < LATENCY; i++)
                meta_d[i] = '0;
        end else if (!hold) begin
            meta_d[0] = in_meta;
            for (int i = 1; i < LATENCY; i++)
                meta_d[i] = meta_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            meta_q <= '{default: '0};
        else
            meta_q <= meta_d;
    end

    assign out_meta = meta_q[LATENCY-1];

    // Data needs no reset: it is only observed when the matching valid is set.
    if (LATENCY > 1) begin : g_data
        logic [DW-1:0] data_q [LATENCY-1];
        logic [DW-1:0] data_d [LATENCY-1];

        always_comb begin
            data_d = data_q;
            if (!hold) begin
                data_d[0] = in_data;
                for (int i = 1; i < LATENCY - 1; i++)
                    data_d[i] = data_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            data_q <= data_d;
        end

        assign out_data = data_q[LATENCY-2];
    end else begin : g_nodata
        assign out_data = in_data;
    end

endmodule

// File: rtl/rom1p1r.sv
// Single-port, single-read ROM bank with registered output and clock enable.
//   clk  : clock
//   ce   : read enable; when low the output register holds its value
//   addr : row address within this bank
//   dout : registered row data (one cycle after addr when ce=1)
// The bank holds every word of the image whose parity matches PARITY.
module rom1p1r
    import irom_banked_pipe_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int PARITY = 0,
    parameter int WORDS  = 4096
) (
    input  logic              clk,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic [ADDR_W:0]   word_idx;
    logic [63:0]       img;

    always_comb begin
        word_idx = {addr, PARITY[0]};
        img      = irom_image(12'(word_idx), 12'(WORDS - 1));
        dout_d   = dout_q;
        if (ce)
            dout_d = img[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/irom_banked_pipe.sv
// Two-bank instruction ROM returning any halfword-aligned 32-bit instruction,
// including fetches that spill across a word boundary, in one access.
//   clk, reset : clock, synchronous active-high reset
//   ReqValid   : request present on ReqAdr
//   ReqAdr     : byte address (bit 0 ignored)
//   ReqReady   : request accepted when ReqValid & ReqReady
//   Flush      : kill all in-flight requests
//   RspReady   : consumer accepts the response
//   RspValid   : response valid
//   RspInstr   : instruction at ReqAdr; zero when RspFault
//   RspFault   : 32-bit window at ReqAdr not fully inside the ROM
module irom_banked_pipe
    import irom_banked_pipe_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter int          ADDR_BITS = 12,
    parameter int          LATENCY   = 1,
    parameter logic [63:0] BASE      = 64'h1000,
    parameter logic [63:0] RANGE     = 64'h7FFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ReqValid,
    input  logic [XLEN-1:0] ReqAdr,
    output logic            ReqReady,
    input  logic            Flush,
    input  logic            RspReady,
    output logic            RspValid,
    output logic [31:0]     RspInstr,
    output logic            RspFault
);

    localparam int              OFF     = $clog2(XLEN / 8);
    localparam int              ROW_W   = ADDR_BITS - 1;
    localparam logic [XLEN-1:0] BASE_X  = BASE[XLEN-1:0];
    // Highest byte offset at which a full 32-bit window still fits.
    localparam logic [XLEN-1:0] LIMIT_X = RANGE[XLEN-1:0] - XLEN'(3);

    logic [XLEN-1:0]      adr;
    logic [XLEN-1:0]      adr_off;
    logic [ADDR_BITS-1:0] w_idx;
    logic [ADDR_BITS-1:0] w_next;
    logic [ROW_W-1:0]     even_row;
    logic [ROW_W-1:0]     odd_row;
    logic                 freeze;
    logic                 accept;
    irom_meta_t           req_meta;
    irom_meta_t           rsp_meta;
    logic [XLEN-1:0]      even_dout;
    logic [XLEN-1:0]      odd_dout;
    logic [2*XLEN-1:0]    rsp_data;
    logic [XLEN-1:0]      rsp_even;
    logic [XLEN-1:0]      rsp_odd;
    logic [2*XLEN-1:0]    pair;

    always_comb begin
        adr      = ReqAdr & ~XLEN'(1);
        adr_off  = adr - BASE_X;
        w_idx    = adr[ADDR_BITS+OFF-1:OFF];
        // Modulo increment: the last word pairs with word 0.
        w_next   = w_idx + ADDR_BITS'(1);
        even_row = w_next[ADDR_BITS-1:1];
        odd_row  = w_idx[ADDR_BITS-1:1];

        freeze   = rsp_meta.valid & ~RspReady;
        ReqReady = ~freeze & ~Flush;
        accept   = ReqValid & ReqReady;

        req_meta       = '0;
        req_meta.valid = accept;
        req_meta.odd   = w_idx[0];
        req_meta.h     = IROM_H_W'(adr[OFF-1:1]);
        req_meta.fault = (adr < BASE_X) || (adr_off > LIMIT_X);
    end

    rom1p1r #(
        .ADDR_W (ROW_W),
        .DATA_W (XLEN),
        .PARITY (0),
        .WORDS  (2 ** ADDR_BITS)
    ) u_bank_even (
        .clk  (clk),
        .ce   (~freeze),
        .addr (even_row),
        .dout (even_dout)
    );

    rom1p1r #(
        .ADDR_W (ROW_W),
        .DATA_W (XLEN),
        .PARITY (1),
        .WORDS  (2 ** ADDR_BITS)
    ) u_bank_odd (
        .clk  (clk),
        .ce   (~freeze),
        .addr (odd_row),
        .dout (odd_dout)
    );

    irom_meta_pipe #(
        .LATENCY (LATENCY),
        .DW      (2 * XLEN)
    ) u_meta_pipe (
        .clk      (clk),
        .reset    (reset),
        .flush    (Flush),
        .hold     (freeze),
        .in_meta  (req_meta),
        .in_data  ({odd_dout, even_dout}),
        .out_meta (rsp_meta),
        .out_data (rsp_data)
    );

    // Pair is {next word, current word}; the current word lives in the bank
    // matching the request's word parity.
    always_comb begin
        rsp_even = rsp_data[XLEN-1:0];
        rsp_odd  = rsp_data[2*XLEN-1:XLEN];
        pair     = rsp_meta.odd ? {rsp_even, rsp_odd} : {rsp_odd, rsp_even};
        RspValid = rsp_meta.valid;
        RspFault = rsp_meta.valid & rsp_meta.fault;
        RspInstr = '0;
        if (rsp_meta.valid && !rsp_meta.fault)
            RspInstr = pair[16*rsp_meta.h +: 32];
    end

endmodule
